// File: rtl/memory_stage_if.sv
// Memory-stage bundle: EM-side controls, data memory port and MW-side results.
// The slave modport is the memory stage itself; master is its environment.
interface memory_stage_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int SP_WIDTH       = 32,
    parameter int MEM_ADDR_WIDTH = 20
);
    logic                      valid_in;
    logic                      mem_read;
    logic                      mem_write;
    logic                      push;
    logic                      pop;
    logic                      push_pc;
    logic                      pop_pc;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [2*DATA_WIDTH-1:0]   pc_in;
    logic [3:0]                reg_dst_num_in;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_we;
    logic [DATA_WIDTH-1:0]     result_out;
    logic [3:0]                reg_dst_num_out;
    logic [DATA_WIDTH-1:0]     reg_dst_value_out;
    logic [SP_WIDTH-1:0]       sp_out;
    logic [2*DATA_WIDTH-1:0]   pc_out;
    logic                      pc_valid;
    logic                      stall_out;
    logic                      out_valid;

    modport slave (
        input  valid_in, mem_read, mem_write, push, pop, push_pc, pop_pc,
               alu_result, store_data, pc_in, reg_dst_num_in, mem_rdata,
        output mem_addr, mem_wdata, mem_we, result_out, reg_dst_num_out,
               reg_dst_value_out, sp_out, pc_out, pc_valid, stall_out, out_valid
    );

    modport master (
        output valid_in, mem_read, mem_write, push, pop, push_pc, pop_pc,
               alu_result, store_data, pc_in, reg_dst_num_in, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, result_out, reg_dst_num_out,
               reg_dst_value_out, sp_out, pc_out, pc_valid, stall_out, out_valid
    );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Pipeline memory stage: loads/stores, 16-bit PUSH/POP and two-cycle 32-bit PC push/pop.
// Owns the stack pointer; all outputs other than sp_out are combinational.
module memory_stage_ctrl #(
    parameter int                  DATA_WIDTH     = 16,
    parameter int                  SP_WIDTH       = 32,
    parameter int                  MEM_ADDR_WIDTH = 20,
    parameter logic [SP_WIDTH-1:0] SP_RESET       = 32'h000F_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    memory_stage_if.slave       bus
);
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [SP_WIDTH-1:0]     sp_r, sp_nxt_s;
    logic [DATA_WIDTH-1:0]   hi_latch_r, hi_latch_nxt_s;
    logic                    op_pop_r, op_pop_nxt_s;

    logic [SP_WIDTH-1:0]     addr_s;
    logic [SP_WIDTH-1:0]     sp_inc_s;
    logic [SP_WIDTH-1:0]     sp_dec_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [DATA_WIDTH-1:0]   result_s;
    logic                    we_s;
    logic                    stall_s;
    logic                    out_valid_s;
    logic                    pc_valid_s;

    assign sp_inc_s = sp_r + SP_WIDTH'(1);
    assign sp_dec_s = sp_r - SP_WIDTH'(1);

    // State register, stack pointer and latched half of a 32-bit pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            sp_r       <= SP_RESET;
            hi_latch_r <= {DATA_WIDTH{1'b0}};
            op_pop_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sp_r       <= sp_nxt_s;
            hi_latch_r <= hi_latch_nxt_s;
            op_pop_r   <= op_pop_nxt_s;
        end
    end

    // Next-state, memory port and result selection
    always_comb begin
        state_nxt_s    = state_r;
        sp_nxt_s       = sp_r;
        hi_latch_nxt_s = hi_latch_r;
        op_pop_nxt_s   = op_pop_r;
        addr_s         = SP_WIDTH'(bus.alu_result);
        wdata_s        = bus.store_data;
        result_s       = bus.alu_result;
        we_s           = 1'b0;
        stall_s        = 1'b0;
        out_valid_s    = 1'b0;
        pc_valid_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (!bus.valid_in) begin
                    out_valid_s = 1'b0;
                end else if (bus.push_pc) begin
                    addr_s       = sp_r;
                    wdata_s      = bus.pc_in[2*DATA_WIDTH-1:DATA_WIDTH];
                    we_s         = 1'b1;
                    sp_nxt_s     = sp_dec_s;
                    stall_s      = 1'b1;
                    op_pop_nxt_s = 1'b0;
                    state_nxt_s  = SECOND;
                end else if (bus.pop_pc) begin
                    // The low half was pushed last, so it is the first word popped
                    addr_s         = sp_inc_s;
                    hi_latch_nxt_s = bus.mem_rdata;
                    sp_nxt_s       = sp_inc_s;
                    stall_s        = 1'b1;
                    op_pop_nxt_s   = 1'b1;
                    state_nxt_s    = SECOND;
                end else if (bus.push) begin
                    addr_s      = sp_r;
                    we_s        = 1'b1;
                    sp_nxt_s    = sp_dec_s;
                    out_valid_s = 1'b1;
                end else if (bus.pop) begin
                    addr_s      = sp_inc_s;
                    result_s    = bus.mem_rdata;
                    sp_nxt_s    = sp_inc_s;
                    out_valid_s = 1'b1;
                end else if (bus.mem_write) begin
                    we_s        = 1'b1;
                    out_valid_s = 1'b1;
                end else if (bus.mem_read) begin
                    result_s    = bus.mem_rdata;
                    out_valid_s = 1'b1;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            SECOND: begin
                if (op_pop_r) begin
                    addr_s      = sp_inc_s;
                    pc_valid_s  = 1'b1;
                    sp_nxt_s    = sp_inc_s;
                end else begin
                    addr_s      = sp_r;
                    wdata_s     = bus.pc_in[DATA_WIDTH-1:0];
                    we_s        = 1'b1;
                    sp_nxt_s    = sp_dec_s;
                end
                out_valid_s = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign bus.mem_addr          = addr_s[MEM_ADDR_WIDTH-1:0];
    assign bus.mem_wdata         = wdata_s;
    assign bus.mem_we            = we_s & reset;
    assign bus.result_out        = result_s;
    assign bus.reg_dst_num_out   = bus.reg_dst_num_in;
    assign bus.reg_dst_value_out = bus.store_data;
    assign bus.sp_out            = sp_r;
    assign bus.pc_out            = {bus.mem_rdata, hi_latch_r};
    assign bus.pc_valid          = pc_valid_s & reset;
    assign bus.stall_out         = stall_s & reset;
    assign bus.out_valid         = out_valid_s & reset;
endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Directed bench for memory_stage_ctrl with a behavioural word-addressed data memory.
module tb_memory_stage_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [15:0] mem [0:1048575];

    memory_stage_if #(.DATA_WIDTH(16), .SP_WIDTH(32), .MEM_ADDR_WIDTH(20)) mif ();

    memory_stage_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mif.mem_rdata = mem[mif.mem_addr];

    always @(posedge clk) begin
        if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        mif.valid_in  = 1'b0;
        mif.mem_read  = 1'b0;
        mif.mem_write = 1'b0;
        mif.push      = 1'b0;
        mif.pop       = 1'b0;
        mif.push_pc   = 1'b0;
        mif.pop_pc    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem[20'hFFFFF] = 16'h0000;
        mem[20'hFFFFE] = 16'h0000;
        mem[20'h00000] = 16'h0000;
        mem[20'h00010] = 16'h0000;
        clear_ops();
        mif.alu_result     = 16'h0000;
        mif.store_data     = 16'h0000;
        mif.pc_in          = 32'h0000_0000;
        mif.reg_dst_num_in = 4'h0;
        reset = 1'b0;

        // reset held for two clocks, with a push requested to prove gating
        mif.valid_in = 1'b1;
        mif.push     = 1'b1;
        tick();
        tick();
        check("rst_sp",        mif.sp_out,    32'h000F_FFFF);
        check("rst_stall",     mif.stall_out, 32'd0);
        check("rst_out_valid", mif.out_valid, 32'd0);
        check("rst_mem_we",    mif.mem_we,    32'd0);
        clear_ops();
        reset = 1'b1;

        // push 0xBEEF
        mif.valid_in = 1'b1; mif.push = 1'b1; mif.store_data = 16'hBEEF;
        mif.reg_dst_num_in = 4'hA;
        #1;
        check("push_we",      mif.mem_we,    32'd1);
        check("push_addr",    mif.mem_addr,  32'h000F_FFFF);
        check("push_wdata",   mif.mem_wdata, 32'h0000_BEEF);
        check("push_ov",      mif.out_valid, 32'd1);
        check("push_stall",   mif.stall_out, 32'd0);
        check("push_rdnum",   mif.reg_dst_num_out,   32'hA);
        check("push_rdval",   mif.reg_dst_value_out, 32'h0000_BEEF);
        tick();
        check("push_sp",      mif.sp_out,    32'h000F_FFFE);
        check("push_mem",     mem[20'hFFFFF], 32'h0000_BEEF);

        // pop
        clear_ops(); mif.valid_in = 1'b1; mif.pop = 1'b1; mif.store_data = 16'h0000;
        #1;
        check("pop_addr",     mif.mem_addr,   32'h000F_FFFF);
        check("pop_result",   mif.result_out, 32'h0000_BEEF);
        check("pop_we",       mif.mem_we,     32'd0);
        tick();
        check("pop_sp",       mif.sp_out,     32'h000F_FFFF);

        // valid_in low: no write, no valid, SP held
        clear_ops(); mif.push = 1'b1;
        #1;
        check("bubble_we",    mif.mem_we,     32'd0);
        check("bubble_ov",    mif.out_valid,  32'd0);
        tick();
        check("bubble_sp",    mif.sp_out,     32'h000F_FFFF);

        // push_pc 0x0001_2345, both halves
        clear_ops(); mif.valid_in = 1'b1; mif.push_pc = 1'b1; mif.push = 1'b1;
        mif.pc_in = 32'h0001_2345;
        #1;
        check("pushpc1_addr",  mif.mem_addr,  32'h000F_FFFF);
        check("pushpc1_wdata", mif.mem_wdata, 32'h0000_0001);
        check("pushpc1_stall", mif.stall_out, 32'd1);
        check("pushpc1_ov",    mif.out_valid, 32'd0);
        tick();
        check("pushpc1_mem",   mem[20'hFFFFF], 32'h0000_0001);
        check("pushpc2_addr",  mif.mem_addr,  32'h000F_FFFE);
        check("pushpc2_wdata", mif.mem_wdata, 32'h0000_2345);
        check("pushpc2_stall", mif.stall_out, 32'd0);
        check("pushpc2_ov",    mif.out_valid, 32'd1);
        tick();
        check("pushpc2_mem",   mem[20'hFFFFE], 32'h0000_2345);
        check("pushpc_sp",     mif.sp_out,    32'h000F_FFFD);

        // pop_pc restores the PC and SP
        clear_ops(); mif.valid_in = 1'b1; mif.pop_pc = 1'b1; mif.pop = 1'b1;
        mif.pc_in = 32'h0000_0000;
        #1;
        check("poppc1_stall",  mif.stall_out, 32'd1);
        check("poppc1_ov",     mif.out_valid, 32'd0);
        check("poppc1_pcv",    mif.pc_valid,  32'd0);
        check("poppc1_we",     mif.mem_we,    32'd0);
        tick();
        check("poppc2_pcv",    mif.pc_valid,  32'd1);
        check("poppc2_pc",     mif.pc_out,    32'h0001_2345);
        check("poppc2_ov",     mif.out_valid, 32'd1);
        check("poppc2_stall",  mif.stall_out, 32'd0);
        tick();
        check("poppc_sp",      mif.sp_out,    32'h000F_FFFF);
        check("poppc_pcv_end", mif.pc_valid,  32'd0);

        // store wins over load when both are set
        clear_ops(); mif.valid_in = 1'b1; mif.mem_write = 1'b1; mif.mem_read = 1'b1;
        mif.alu_result = 16'h0020; mif.store_data = 16'h7777;
        #1;
        check("prio_we",       mif.mem_we,    32'd1);
        tick();
        check("prio_mem",      mem[20'h00020], 32'h0000_7777);

        // load returns memory data; plain ALU op returns alu_result
        clear_ops(); mif.valid_in = 1'b1; mif.mem_read = 1'b1;
        #1;
        check("load_result",   mif.result_out, 32'h0000_7777);
        mif.mem_read = 1'b0; mif.alu_result = 16'h1357;
        #1;
        check("alu_result",    mif.result_out, 32'h0000_1357);
        check("alu_ov",        mif.out_valid,  32'd1);
        tick();

        // SP wrap: push at 0 then pop
        clear_ops();
        force dut.sp_r = 32'h0000_0000;
        #1;
        release dut.sp_r;
        #1;
        check("wrap_sp0",      mif.sp_out,    32'h0000_0000);
        mif.valid_in = 1'b1; mif.push = 1'b1; mif.store_data = 16'h1234;
        #1;
        check("wrap_push_addr", mif.mem_addr, 32'h0000_0000);
        tick();
        check("wrap_push_sp",  mif.sp_out,    32'hFFFF_FFFF);
        check("wrap_push_mem", mem[20'h00000], 32'h0000_1234);
        clear_ops(); mif.valid_in = 1'b1; mif.pop = 1'b1;
        #1;
        check("wrap_pop_addr", mif.mem_addr,   32'h0000_0000);
        check("wrap_pop_res",  mif.result_out, 32'h0000_1234);
        tick();
        check("wrap_pop_sp",   mif.sp_out,     32'h0000_0000);

        // reset during SECOND of push_pc aborts the second write
        mem[20'hFFFFF] = 16'h0001;
        clear_ops(); mif.valid_in = 1'b1; mif.push_pc = 1'b1; mif.pc_in = 32'hABCD_5678;
        tick();
        check("abort_sp_mid",  mif.sp_out,    32'hFFFF_FFFF);
        reset = 1'b0;
        #1;
        check("abort_we",      mif.mem_we,    32'd0);
        check("abort_stall",   mif.stall_out, 32'd0);
        tick();
        check("abort_mem",     mem[20'hFFFFF], 32'h0000_0001);
        check("abort_sp",      mif.sp_out,    32'h000F_FFFF);
        reset = 1'b1;
        clear_ops(); mif.valid_in = 1'b1; mif.mem_write = 1'b1;
        mif.alu_result = 16'h0010; mif.store_data = 16'h0055;
        #1;
        check("post_addr",     mif.mem_addr,  32'h0000_0010);
        check("post_ov",       mif.out_valid, 32'd1);
        tick();
        check("post_mem",      mem[20'h00010], 32'h0000_0055);
        clear_ops();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
